// File: rtl/aes_pkg.sv
// Shared AES types, block size constants and the ShiftRows byte-index map.
package aes_pkg;

    typedef logic [7:0]   aes_byte_t;
    typedef logic [127:0] aes_state_t;

    localparam int unsigned AES_BLOCK_BYTES = 16;
    localparam int unsigned AES_BLOCK_BITS  = 8 * AES_BLOCK_BYTES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_bytes_state_t;

    // Byte k sits at row k%4, column k/4; output (r,c) takes input (r,(c+r)%4).
    function automatic int unsigned shift_rows_idx(input int unsigned k);
        int unsigned r;
        int unsigned c;
        r = k % 4;
        c = k / 4;
        return r + 4 * ((c + r) % 4);
    endfunction

endpackage

// File: rtl/aes_sub_bytes_lane.sv
// Substitutes a bytes_per_cycle_p-byte slice through parallel S-box lookups.
module aes_sub_bytes_lane #(
    parameter int unsigned bytes_per_cycle_p = 4
) (
    input  logic [8*bytes_per_cycle_p-1:0] data_i,
    output logic [8*bytes_per_cycle_p-1:0] data_o
);

    for (genvar b = 0; b < bytes_per_cycle_p; b++) begin : g_sbox
        rom_sbox u_sbox (
            .addr_i (data_i[8*b +: 8]),
            .data_o (data_o[8*b +: 8])
        );
    end

endmodule

// File: rtl/rom_sbox.sv
// AES forward S-box as a combinational 256-entry lookup table.
module rom_sbox (
    input  logic [7:0] addr_i,
    output logic [7:0] data_o
);

    localparam logic [0:255][7:0] sbox_table = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign data_o = sbox_table[addr_i];

endmodule

// File: rtl/aes_sub_bytes_iter.sv
// Iterative AES SubBytes: bytes_per_cycle_p registered S-box lookups per cycle.
// Define AES_SUB_BYTES_SHIFTROWS_EN to also apply ShiftRows to data_o.
module aes_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int unsigned bytes_per_cycle_p = 4
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [127:0] data_i,
    input  logic         v_i,
    output logic         ready_o,
    output logic [127:0] data_o,
    output logic         v_o,
    input  logic         yumi_i
);

    localparam int unsigned num_steps = AES_BLOCK_BYTES / bytes_per_cycle_p;
    localparam int unsigned step_w    = (num_steps > 1) ? $clog2(num_steps) : 1;
    localparam int unsigned slice_w   = 8 * bytes_per_cycle_p;

    if (bytes_per_cycle_p != 1 && bytes_per_cycle_p != 2 && bytes_per_cycle_p != 4 &&
        bytes_per_cycle_p != 8 && bytes_per_cycle_p != 16) begin : g_bad_bpc
        $fatal(1, "aes_sub_bytes_iter: bytes_per_cycle_p must be 1, 2, 4, 8 or 16");
    end

    sub_bytes_state_t    state;
    logic [step_w-1:0]   step;
    aes_state_t          in_reg;
    aes_state_t          res_reg;
    aes_state_t          next_res;
    aes_state_t          out_state;
    logic [slice_w-1:0]  slice_in;
    logic [slice_w-1:0]  slice_out;

    assign ready_o = (state == IDLE) & ~reset_i;

    always_comb begin
        slice_in = '0;
        for (int unsigned s = 0; s < num_steps; s++) begin
            if (step == step_w'(s)) begin
                slice_in = in_reg[AES_BLOCK_BITS-1 - s*slice_w -: slice_w];
            end
        end
    end

    aes_sub_bytes_lane #(
        .bytes_per_cycle_p (bytes_per_cycle_p)
    ) u_lane (
        .data_i (slice_in),
        .data_o (slice_out)
    );

    // Merge the current slice so the final step can load data_o in the same edge.
    always_comb begin
        next_res = res_reg;
        for (int unsigned s = 0; s < num_steps; s++) begin
            if (step == step_w'(s)) begin
                next_res[AES_BLOCK_BITS-1 - s*slice_w -: slice_w] = slice_out;
            end
        end
    end

`ifdef AES_SUB_BYTES_SHIFTROWS_EN
    always_comb begin
        out_state = '0;
        for (int unsigned k = 0; k < AES_BLOCK_BYTES; k++) begin
            out_state[AES_BLOCK_BITS-1 - 8*k -: 8] =
                next_res[AES_BLOCK_BITS-1 - 8*shift_rows_idx(k) -: 8];
        end
    end
`else
    assign out_state = next_res;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state  <= IDLE;
            v_o    <= 1'b0;
            data_o <= '0;
            step   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (v_i) begin
                        in_reg <= data_i;
                        step   <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    res_reg <= next_res;
                    if (step == step_w'(num_steps - 1)) begin
                        state  <= DONE;
                        v_o    <= 1'b1;
                        data_o <= out_state;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                DONE: begin
                    if (yumi_i) begin
                        state <= IDLE;
                        v_o   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !v_o))
                else $error("aes_sub_bytes_iter: yumi_i asserted while v_o is low");
        end
    end

endmodule

// File: tb/tb_aes_sub_bytes_iter.sv
// Directed bench for aes_sub_bytes_iter at bytes_per_cycle_p=4 and =1; honours AES_SUB_BYTES_SHIFTROWS_EN.
module tb_aes_sub_bytes_iter;
    import aes_pkg::*;

    logic       clk;
    logic       reset;
    aes_state_t a_data, a_do, b_data, b_do;
    logic       a_v, a_ready, a_vo, a_yumi;
    logic       b_v, b_ready, b_vo, b_yumi;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [7:0]  sbox_m [256];

    aes_sub_bytes_iter #(.bytes_per_cycle_p(4)) dut_a (
        .clk_i(clk), .reset_i(reset), .data_i(a_data), .v_i(a_v), .ready_o(a_ready),
        .data_o(a_do), .v_o(a_vo), .yumi_i(a_yumi)
    );

    aes_sub_bytes_iter #(.bytes_per_cycle_p(1)) dut_b (
        .clk_i(clk), .reset_i(reset), .data_i(b_data), .v_i(b_v), .ready_o(b_ready),
        .data_o(b_do), .v_o(b_vo), .yumi_i(b_yumi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Reference S-box from GF(2^8) inversion plus the affine transform.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            sbox_m[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic aes_state_t model(input aes_state_t x);
        aes_state_t s;
        aes_state_t o;
        for (int k = 0; k < 16; k++) s[127-8*k -: 8] = sbox_m[x[127-8*k -: 8]];
`ifdef AES_SUB_BYTES_SHIFTROWS_EN
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
`else
        o = s;
`endif
        return o;
    endfunction

    function automatic aes_state_t rnd_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic xfer_a(input aes_state_t din, output aes_state_t dout, output int lat);
        int n = 0;
        a_data = din;
        a_v    = 1'b1;
        while (!a_ready && n < 40) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        a_v = 1'b0;
        lat = 1;
        while (!a_vo && lat < 60) begin @(posedge clk); #1; lat++; end
        dout   = a_do;
        a_yumi = a_vo;
        @(posedge clk); #1;
        a_yumi = 1'b0;
    endtask

    task automatic xfer_b(input aes_state_t din, output aes_state_t dout, output int lat);
        int n = 0;
        b_data = din;
        b_v    = 1'b1;
        while (!b_ready && n < 40) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        b_v = 1'b0;
        lat = 1;
        while (!b_vo && lat < 60) begin @(posedge clk); #1; lat++; end
        dout   = b_do;
        b_yumi = b_vo;
        @(posedge clk); #1;
        b_yumi = 1'b0;
    endtask

    initial begin
        aes_state_t res, exp_fips, second, r1, r2, held;
        aes_state_t q[$];
        int lat, n, cyc, sent, got, last_acc;
        logic acc;

`ifdef AES_SUB_BYTES_SHIFTROWS_EN
        exp_fips = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
`else
        exp_fips = 128'hd42711aee0bf98f1b8b45de51e415230;
`endif
        build_sbox();

        reset = 1'b1;
        a_data = '0; a_v = 1'b0; a_yumi = 1'b0;
        b_data = '0; b_v = 1'b0; b_yumi = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_ready", 128'(a_ready), 128'(0));
        chk("rst_a_vo",    128'(a_vo),    128'(0));
        chk("rst_a_data",  a_do,          '0);
        chk("rst_b_ready", 128'(b_ready), 128'(0));
        chk("rst_b_vo",    128'(b_vo),    128'(0));
        chk("rst_b_data",  b_do,          '0);
        reset = 1'b0;
        #1;
        chk("idle_a_ready", 128'(a_ready), 128'(1));
        chk("idle_b_ready", 128'(b_ready), 128'(1));

        // FIPS-197 Appendix B, round 1
        xfer_a(128'h193de3bea0f4e22b9ac68d2ae9f84808, res, lat);
        chk("fips_data", res, exp_fips);
        chk("fips_lat",  128'(lat), 128'(5));

        xfer_b('0, res, lat);
        chk("b_zero_data", res, {16{8'h63}});
        chk("b_zero_lat",  128'(lat), 128'(17));
        xfer_b('1, res, lat);
        chk("b_ff_data", res, {16{8'h16}});
        chk("b_ff_lat",  128'(lat), 128'(17));

        // Backpressure: result must hold while a new block waits on v_i
        second = 128'h00112233445566778899aabbccddeeff;
        a_data = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        a_v = 1'b1;
        @(posedge clk); #1;
        a_data = second;
        n = 0;
        while (!a_vo && n < 20) begin @(posedge clk); #1; n++; end
        held = a_do;
        chk("bp_first", held, exp_fips);
        for (int i = 0; i < 10; i++) begin
            chk("bp_vo",    128'(a_vo),    128'(1));
            chk("bp_data",  a_do,          exp_fips);
            chk("bp_ready", 128'(a_ready), 128'(0));
            @(posedge clk); #1;
        end
        a_yumi = 1'b1;
        @(posedge clk); #1;
        a_yumi = 1'b0;
        chk("bp_ready_after", 128'(a_ready), 128'(1));
        chk("bp_vo_after",    128'(a_vo),    128'(0));
        @(posedge clk); #1;
        chk("bp_accept", 128'(a_ready), 128'(0));
        a_v = 1'b0;
        lat = 1;
        while (!a_vo && lat < 60) begin @(posedge clk); #1; lat++; end
        chk("bp_second_data", a_do, model(second));
        chk("bp_second_lat",  128'(lat), 128'(5));
        a_yumi = a_vo;
        @(posedge clk); #1;
        a_yumi = 1'b0;

        // Reset with the block at step 2 of 4
        r1 = rnd_state();
        r2 = rnd_state();
        a_data = r1;
        a_v = 1'b1;
        @(posedge clk); #1;
        a_v = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("midrst_vo",    128'(a_vo),    128'(0));
        chk("midrst_ready", 128'(a_ready), 128'(1));
        chk("midrst_data",  a_do,          '0);
        xfer_a(r2, res, lat);
        chk("midrst_next_data", res, model(r2));
        chk("midrst_next_lat",  128'(lat), 128'(5));

        // Streaming with yumi_i following v_o
        sent = 0; got = 0; last_acc = -1; cyc = 0;
        a_data = rnd_state();
        a_v = 1'b1;
        while (got < 8 && cyc < 150) begin
            acc = a_v && a_ready;
            if (a_vo) begin
                chk("stream_pending", 128'(q.size() != 0), 128'(1));
                if (q.size() != 0) chk("stream_data", a_do, q.pop_front());
                got++;
            end
            a_yumi = a_vo;
            if (acc) begin
                q.push_back(model(a_data));
                sent++;
                if (last_acc >= 0) chk("stream_gap", 128'(cyc - last_acc), 128'(6));
                last_acc = cyc;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (sent == 8) a_v = 1'b0;
                else a_data = rnd_state();
            end
        end
        a_yumi = 1'b0;
        a_v = 1'b0;
        chk("stream_sent",  128'(sent),     128'(8));
        chk("stream_got",   128'(got),      128'(8));
        chk("stream_left",  128'(q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_sub_bytes_iter.md
Name: aes_sub_bytes_iter

Overview:
- Iterative AES SubBytes stage. Accepts one 128-bit state and substitutes every byte through registered S-box lookups, bytes_per_cycle_p bytes per cycle.
- Presents the result on a valid/yumi output.
- Sits directly downstream of the round-key XOR (AddRoundKey) and upstream of ShiftRows/MixColumns.
- Limits the S-box depth to one lookup per clock, register to register, which bounds the timing path.

Parameters:
- bytes_per_cycle_p, 4, S-box lookups per cycle. Legal values: 1, 2, 4, 8, 16; any other value is a fatal elaboration error.
- Derived constant: num_steps = 16 / bytes_per_cycle_p.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset, synchronous, active-high
- data_i  in  128  input state; FIPS-197 byte order, byte 0 = data_i[127:120], byte k at row k%4, column k/4
- v_i  in  1  input valid
- ready_o  out  1  block can accept; v_i && ready_o = accept
- data_o  out  128  substituted state, same byte order as data_i
- v_o  out  1  output valid
- yumi_i  in  1  consumer takes data_o; legal only when v_o=1

Behaviour:
- Clock and reset: one clock, clk_i. Reset reset_i is synchronous and active-high.
- Reset values: state=IDLE, v_o=0, data_o=0, step counter=0.
- ready_o = (state==IDLE) & ~reset_i. It has no combinational dependence on yumi_i or v_i.
- State machine:
  - IDLE: on accept, capture data_i into the input register, clear the step counter, go to BUSY.
  - BUSY: each cycle, bytes [step*bpc .. step*bpc+bpc-1] of the input register pass through S-box lookups and are written into the matching bytes of the result register. Then step++. When step==num_steps-1, go to DONE.
  - DONE: v_o=1, data_o = result register. Both are held stable until yumi_i. On yumi_i, go to IDLE.
- Latency: accept at edge E means v_o is high num_steps+1 cycles after E (5 for the default).
- Throughput: one block per num_steps+2 cycles; there is no overlap between blocks.
- v_i while not in IDLE is ignored and never captured.
- yumi_i while v_o=0 is an illegal protocol event; assert it in simulation.
- Reset asserted in any state: the block returns to IDLE on that edge. An in-flight block is discarded and v_o drops the next cycle. No partial result is ever presented.
- data_o changes only on the edge that enters DONE (or on reset); it does not change while waiting for yumi_i.
- Byte substitution is the standard AES forward S-box. All lookups are combinational from the input register plus the step mux, and registered into the result.

Optional Feature:
- Macro: AES_SUB_BYTES_SHIFTROWS_EN.
- Defined: data_o carries SubBytes followed by ShiftRows. Output byte (r,c) = substituted input byte (r,(c+r)%4), i.e. output index r+4c takes substituted index r+4((c+r)%4). The permutation is wiring only, so latency is unchanged.
- Undefined: data_o carries SubBytes only.

Decomposition:
- Package aes_pkg:
  - typedef aes_byte_t = logic[7:0]
  - typedef aes_state_t = logic[127:0]
  - constant AES_BLOCK_BYTES=16
  - function shift_rows_idx(k) returning the source index
- Sub-module: aes_sub_bytes_lane. It holds bytes_per_cycle_p instances of the existing rom_sbox and maps a bpc-byte slice to its substitution.
- The FSM, counter and registers stay in the top module.

Test Plan:
- FIPS-197 Appendix B round 1, feature off: data_i=193de3bea0f4e22b9ac68d2ae9f84808 -> data_o=d42711aee0bf98f1b8b45de51e415230. v_o rises 5 cycles after accept.
- Same vector, feature on: data_o=d4bf5d30e0b452aeb84111f11e2798e5.
- All-zero input, then all-FF input, with bytes_per_cycle_p=1: data_o=6363…63 (16 bytes), then 1616…16. Latency is 17 cycles each.
- Backpressure: hold yumi_i=0 for 10 cycles with v_i=1 and new data_i:
  - v_o=1 and data_o stable throughout; ready_o=0.
  - After yumi_i, ready_o=1 the next cycle and the new block is accepted.
- Reset mid-BUSY (step 2 of 4): v_o=0 and ready_o=1 on the next cycle. A subsequent block returns the correct result with no stale bytes.
- Streaming: v_i held high and yumi_i tied to v_o for 8 random blocks. The bench checks for exactly one accept per 6 cycles, in-order results matching a reference model, and no dropped or duplicated blocks.
